// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SDRAM controller command port.
// The master modport is the arbiter's view; slave is the view of the surrounding environment.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              ctl_cmd;
  logic              ctl_we;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_done;
  logic [DATA_W-1:0] ctl_rdata;

  logic              busy;
  logic              grant;
  logic              timeout;

  modport master (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  ctl_done, ctl_rdata,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output ctl_cmd, ctl_we, ctl_addr, ctl_wdata,
    output busy, grant, timeout
  );

  modport slave (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output ctl_done, ctl_rdata,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  ctl_cmd, ctl_we, ctl_addr, ctl_wdata,
    input  busy, grant, timeout
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port fixed-priority arbiter (port 0 favoured, port 1 protected by a starvation limit) in front of one SDRAM command port.
// Optional WAIT-state watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 16,
  parameter int MAX_STARVE     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 Clk,
  input logic                 Reset_n,
  sdram_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = $clog2(MAX_STARVE + 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_starve;
  logic              r_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;

  logic w_pick1;
  logic w_pick0;
  logic w_to_hit;

  assign w_pick1 = bus.p1_req && (!bus.p0_req || (r_starve == CNT_W'(MAX_STARVE)));
  assign w_pick0 = !w_pick1 && bus.p0_req;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  // A late ctl_done on the limit cycle still wins, so the watchdog only fires without it.
  assign w_to_hit = (r_state == WAIT) && !bus.ctl_done &&
                    (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
      if (r_state == ISSUE) begin
        r_to_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_pick0 || w_pick1) w_next = ISSUE;
      ISSUE: w_next = WAIT;
      WAIT:  if (bus.ctl_done || w_to_hit) w_next = RESP;
      RESP:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Command latches and per-port read data; rdata only ever changes on a read of that same port.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_grant    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_pick1) begin
        r_grant <= 1'b1;
        r_we    <= bus.p1_we;
        r_addr  <= bus.p1_addr;
        r_wdata <= bus.p1_wdata;
      end else if (r_state == IDLE && w_pick0) begin
        r_grant <= 1'b0;
        r_we    <= bus.p0_we;
        r_addr  <= bus.p0_addr;
        r_wdata <= bus.p0_wdata;
      end

      if (r_state == WAIT && !r_we && (bus.ctl_done || w_to_hit)) begin
        if (r_grant) begin
          r_p1_rdata <= bus.ctl_done ? bus.ctl_rdata : DATA_W'(16'hDEAD);
        end else begin
          r_p0_rdata <= bus.ctl_done ? bus.ctl_rdata : DATA_W'(16'hDEAD);
        end
      end
    end
  end

  // Counts port-0 wins that happened while port 1 was waiting.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_starve <= '0;
    end else if (!bus.p1_req) begin
      r_starve <= '0;
    end else if (r_state == IDLE && w_pick1) begin
      r_starve <= '0;
    end else if (r_state == IDLE && w_pick0 && r_starve != CNT_W'(MAX_STARVE)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_comb begin
    bus.ctl_cmd   = (r_state == ISSUE);
    bus.ctl_we    = r_we;
    bus.ctl_addr  = r_addr;
    bus.ctl_wdata = r_wdata;
    bus.busy      = (r_state != IDLE);
    bus.grant     = r_grant;
    bus.p0_ack    = (r_state == RESP) && !r_grant;
    bus.p1_ack    = (r_state == RESP) && r_grant;
    bus.p0_rdata  = r_p0_rdata;
    bus.p1_rdata  = r_p1_rdata;
`ifdef SDRAM_ARB_TIMEOUT_EN
    bus.timeout   = (r_state == RESP) && r_timeout;
`else
    bus.timeout   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter; inputs change and outputs are sampled on the falling clock edge.
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  always #5 Clk = ~Clk;

  task automatic waitCmd(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (bus.ctl_cmd === 1'b1) begin
        ok = 1'b1;
        n  = i;
        break;
      end
    end
  endtask

  // Called on the ctl_cmd negedge; returns on the negedge where RESP is visible.
  task automatic pulseDone(input int d, input logic [DATA_W-1:0] data);
    repeat (d) @(negedge Clk);
    bus.ctl_done  = 1'b1;
    bus.ctl_rdata = data;
    @(negedge Clk);
    bus.ctl_done  = 1'b0;
    bus.ctl_rdata = '0;
  endtask

  task automatic test_reset();
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
    bus.ctl_done = 0; bus.ctl_rdata = '0;
    Reset_n = 1'b0;
    @(negedge Clk);
    tests++;
    if ({bus.busy, bus.ctl_cmd, bus.p0_ack, bus.p1_ack, bus.grant, bus.timeout} !== 6'b0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {bus.busy, bus.ctl_cmd, bus.p0_ack, bus.p1_ack, bus.grant, bus.timeout});
    end
    tests++;
    if (bus.ctl_addr !== '0 || bus.p0_rdata !== '0 || bus.p1_rdata !== '0) begin
      fails++;
      $display("[TB] FAIL reset_data: addr %h rd0 %h rd1 %h expected zeros",
               bus.ctl_addr, bus.p0_rdata, bus.p1_rdata);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_p0_read();
    bit ok; int n;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 25'h0000A34;
    waitCmd(ok, n);
    tests++;
    if (!ok || n != 1) begin
      fails++;
      $display("[TB] FAIL p0rd_cmd_latency: got ok=%0b n=%0d expected ok=1 n=1", ok, n);
    end
    tests++;
    if (bus.ctl_addr !== 25'h0000A34 || bus.ctl_we !== 1'b0 || bus.grant !== 1'b0) begin
      fails++;
      $display("[TB] FAIL p0rd_cmd: addr %h we %b grant %b expected 0000a34 0 0",
               bus.ctl_addr, bus.ctl_we, bus.grant);
    end
    @(negedge Clk);
    tests++;
    if (bus.ctl_cmd !== 1'b0 || bus.ctl_addr !== 25'h0000A34) begin
      fails++;
      $display("[TB] FAIL p0rd_cmd_width: cmd %b addr %h expected 0 0000a34", bus.ctl_cmd, bus.ctl_addr);
    end
    pulseDone(2, 16'hBEEF);
    tests++;
    if (bus.p0_ack !== 1'b1 || bus.p0_rdata !== 16'hBEEF || bus.p1_ack !== 1'b0) begin
      fails++;
      $display("[TB] FAIL p0rd_ack: ack0 %b rd0 %h ack1 %b expected 1 beef 0",
               bus.p0_ack, bus.p0_rdata, bus.p1_ack);
    end
    bus.p0_req = 0;
    @(negedge Clk);
    tests++;
    if (bus.p0_ack !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL p0rd_idle: ack0 %b busy %b expected 0 0", bus.p0_ack, bus.busy);
    end
  endtask

  task automatic test_p1_write();
    bit ok; int n;
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 25'h1; bus.p1_wdata = 16'h1234;
    waitCmd(ok, n);
    tests++;
    if (!ok || bus.ctl_we !== 1'b1 || bus.ctl_wdata !== 16'h1234 || bus.grant !== 1'b1) begin
      fails++;
      $display("[TB] FAIL p1wr_cmd: ok %0b we %b wdata %h grant %b expected 1 1 1234 1",
               ok, bus.ctl_we, bus.ctl_wdata, bus.grant);
    end
    pulseDone(1, 16'hFFFF);
    tests++;
    if (n + 2 != 3 || bus.p1_ack !== 1'b1) begin
      fails++;
      $display("[TB] FAIL p1wr_ack_latency: ack1 %b after %0d cycles expected 1 after 3", bus.p1_ack, n + 2);
    end
    tests++;
    if (bus.p1_rdata !== 16'h0000 || bus.p0_rdata !== 16'hBEEF) begin
      fails++;
      $display("[TB] FAIL p1wr_rdata_hold: rd1 %h rd0 %h expected 0000 beef", bus.p1_rdata, bus.p0_rdata);
    end
    bus.p1_req = 0; bus.p1_we = 0;
    @(negedge Clk);
  endtask

  task automatic test_p1_read();
    bit ok; int n;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 25'h1ABCDEF;
    waitCmd(ok, n);
    pulseDone(1, 16'h7777);
    tests++;
    if (!ok || bus.p1_ack !== 1'b1 || bus.p1_rdata !== 16'h7777 || bus.p0_rdata !== 16'hBEEF) begin
      fails++;
      $display("[TB] FAIL p1rd: ok %0b ack1 %b rd1 %h rd0 %h expected 1 1 7777 beef",
               ok, bus.p1_ack, bus.p1_rdata, bus.p0_rdata);
    end
    bus.p1_req = 0;
    @(negedge Clk);
  endtask

  task automatic test_starvation();
    bit ok; int n;
    logic exp_grant [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 25'h100; bus.p0_wdata = 16'h0101;
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 25'h200; bus.p1_wdata = 16'h0202;
    for (int i = 0; i < 10; i++) begin
      waitCmd(ok, n);
      tests++;
      if (!ok || bus.grant !== exp_grant[i]) begin
        fails++;
        $display("[TB] FAIL starve_grant[%0d]: ok %0b grant %b expected 1 %b", i, ok, bus.grant, exp_grant[i]);
      end
      pulseDone(1, 16'h0);
      if (i == 9) begin
        bus.p0_req = 0;
        bus.p1_req = 0;
      end
    end
    @(negedge Clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.p0_rdata !== 16'hBEEF || bus.p1_rdata !== 16'h7777) begin
      fails++;
      $display("[TB] FAIL starve_end: busy %b rd0 %h rd1 %h expected 0 beef 7777",
               bus.busy, bus.p0_rdata, bus.p1_rdata);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int n;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 25'h0000055;
    waitCmd(ok, n);
    @(negedge Clk);
    tests++;
    if (!ok || bus.busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rstmid_wait: ok %0b busy %b expected 1 1", ok, bus.busy);
    end
    Reset_n = 1'b0;
    bus.p0_req = 0;
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.p0_rdata !== 16'h0) begin
      fails++;
      $display("[TB] FAIL rstmid_async: busy %b rd0 %h expected 0 0000", bus.busy, bus.p0_rdata);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    pulseDone(1, 16'h1111);
    tests++;
    if (bus.p0_ack !== 1'b0 || bus.busy !== 1'b0 || bus.p0_rdata !== 16'h0) begin
      fails++;
      $display("[TB] FAIL rstmid_late_done: ack0 %b busy %b rd0 %h expected 0 0 0000",
               bus.p0_ack, bus.busy, bus.p0_rdata);
    end
    bus.p0_req = 1; bus.p0_addr = 25'h0000066;
    waitCmd(ok, n);
    tests++;
    if (!ok || n != 1 || bus.ctl_addr !== 25'h0000066) begin
      fails++;
      $display("[TB] FAIL rstmid_next_cmd: ok %0b n %0d addr %h expected 1 1 0000066", ok, n, bus.ctl_addr);
    end
    pulseDone(1, 16'h5A5A);
    tests++;
    if (bus.p0_ack !== 1'b1 || bus.p0_rdata !== 16'h5A5A) begin
      fails++;
      $display("[TB] FAIL rstmid_next_ack: ack0 %b rd0 %h expected 1 5a5a", bus.p0_ack, bus.p0_rdata);
    end
    bus.p0_req = 0;
    @(negedge Clk);
  endtask

  task automatic test_req_drop();
    bit ok; int n;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 25'h0000777;
    waitCmd(ok, n);
    @(negedge Clk);
    bus.p0_req = 0;
    pulseDone(1, 16'hC0DE);
    tests++;
    if (!ok || bus.p0_ack !== 1'b1 || bus.p0_rdata !== 16'hC0DE) begin
      fails++;
      $display("[TB] FAIL drop_ack: ok %0b ack0 %b rd0 %h expected 1 1 c0de", ok, bus.p0_ack, bus.p0_rdata);
    end
    repeat (2) @(negedge Clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.ctl_cmd !== 1'b0) begin
      fails++;
      $display("[TB] FAIL drop_no_rearb: busy %b cmd %b expected 0 0", bus.busy, bus.ctl_cmd);
    end
  endtask

  task automatic test_timeout();
    bit ok; int n;
    int ackAt;
    bit sawBad;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 25'h0000ABC;
    waitCmd(ok, n);
    ackAt  = 0;
    sawBad = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (bus.p1_ack === 1'b1) begin
        ackAt = k;
        if (bus.timeout !== 1'b1) sawBad = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok || ackAt != 17 || sawBad || bus.p1_rdata !== 16'hDEAD) begin
      fails++;
      $display("[TB] FAIL timeout_fire: ok %0b ack at %0d tobad %0b rd1 %h expected 1 17 0 dead",
               ok, ackAt, sawBad, bus.p1_rdata);
    end
    bus.p1_req = 0;
    @(negedge Clk);
`else
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (bus.busy !== 1'b1 || bus.timeout !== 1'b0 || bus.p1_ack !== 1'b0) sawBad = 1'b1;
    end
    tests++;
    if (!ok || sawBad) begin
      fails++;
      $display("[TB] FAIL timeout_disabled: ok %0b bad %0b expected 1 0", ok, sawBad);
    end
    pulseDone(0, 16'h4242);
    tests++;
    if (bus.p1_ack !== 1'b1 || bus.timeout !== 1'b0 || bus.p1_rdata !== 16'h4242) begin
      fails++;
      $display("[TB] FAIL timeout_late_done: ack1 %b to %b rd1 %h expected 1 0 4242",
               bus.p1_ack, bus.timeout, bus.p1_rdata);
    end
    bus.p1_req = 0;
    @(negedge Clk);
`endif
  endtask

  initial begin
    test_reset();
    test_p0_read();
    test_p1_write();
    test_p1_read();
    test_starvation();
    test_reset_mid();
    test_req_drop();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one single-word SDRAM controller command port between two requesters.
- Port 0 is the high-priority VGA line fetch. Port 1 is the general read/write port (test/debug, sprite loader).
- Fixed priority to port 0, with a starvation limit that guarantees port 1 service.
- Sequences each transaction: grant, one-cycle command pulse, wait for completion, one-cycle ack with read data.

Parameters:
- ADDR_W, 25, SDRAM word address width.
- DATA_W, 16, SDRAM data width.
- MAX_STARVE, 4, consecutive port-0 grants allowed while port 1 is pending.
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit; used only with the optional feature.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request; level, held until p0_ack.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p0_rdata  out  DATA_W  port 0 read data; valid with p0_ack on reads.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1.
- ctl_cmd  out  1  one-cycle command strobe to the SDRAM controller.
- ctl_we  out  1  command type.
- ctl_addr  out  ADDR_W  latched command address.
- ctl_wdata  out  DATA_W  latched write data.
- ctl_done  in  1  controller completion pulse.
- ctl_rdata  in  DATA_W  controller read data; valid with ctl_done.
- busy  out  1  high in every state except IDLE.
- grant  out  1  owning port index; holds its last value while in IDLE.
- timeout  out  1  one-cycle watchdog error pulse; tied 0 without the optional feature.

Behaviour:
- Reset (Reset_n low, async): state = IDLE; all outputs 0; latched cmd regs 0; starve_cnt = 0.
- All state changes happen on posedge Clk.

State machine:
- IDLE
  - Pick port 1 if p1_req && (!p0_req || starve_cnt == MAX_STARVE).
  - Else pick port 0 if p0_req.
  - Else stay in IDLE.
  - On a pick: latch we/addr/wdata of the winner, set grant, go to ISSUE.
- ISSUE
  - ctl_cmd = 1 for exactly this cycle, with ctl_we/ctl_addr/ctl_wdata driven from the latches.
  - Go to WAIT.
- WAIT
  - ctl_cmd = 0. Hold ctl_addr/ctl_we/ctl_wdata stable.
  - On ctl_done: if the op is a read, capture ctl_rdata into the granted port's rdata; go to RESP.
- RESP
  - Granted port's ack = 1 for this cycle only; go to IDLE.

starve_cnt:
- Increments, saturating at MAX_STARVE, on each port-0 grant made while p1_req is high.
- Clears on a port-1 grant, or in any cycle where p1_req is low.

Latency and handshake:
- Minimum latency: request sampled in IDLE at cycle N → ctl_cmd at N+1 → ctl_done at N+2 at the earliest → ack at N+3.
- Throughput: at most one transaction per 4 cycles.
- A requester holding req high after ack is re-arbitrated in the IDLE cycle following RESP.

Boundary conditions:
- rdata is not modified by writes or by transactions of the other port; it holds its last read value.
- req deasserted mid-transaction: the transaction still completes and ack still pulses.
- ctl_done outside WAIT is ignored.
- Reset mid-transaction: immediate return to IDLE. A later ctl_done from the controller is ignored.
- Both reqs rise in the same cycle with starve_cnt < MAX_STARVE: port 0 wins.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without ctl_done: go to RESP; the granted rdata is loaded with 16'hDEAD on reads; timeout pulses in the same cycle as ack.
  - ctl_done in the same cycle as the limit takes priority (normal completion, no timeout).
- Undefined:
  - No counter; WAIT waits indefinitely; timeout is constant 0.

Test Plan:
- p0 read, addr 25'h0000A34; controller returns 16'hBEEF 3 cycles after ctl_cmd → ctl_cmd one cycle with ctl_addr = 25'h0000A34, ctl_we = 0; p0_ack with p0_rdata = 16'hBEEF; p1_ack stays 0.
- p1 write, addr 25'h1, wdata 16'h1234, ctl_done 1 cycle after ctl_cmd → ctl_we = 1, ctl_wdata = 16'h1234; p1_ack 3 cycles after req sampled; p1_rdata unchanged.
- p0 and p1 held high continuously, MAX_STARVE = 4 → grant sequence 0,0,0,0,1,0,0,0,0,1.
- Reset_n pulsed low while in WAIT, then ctl_done pulsed after release → no ack, busy = 0, state IDLE; next p0 request serviced normally.
- With SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, ctl_done never asserted on a p1 read → p1_ack and timeout pulse together 16 cycles after WAIT entry, p1_rdata = 16'hDEAD; without the macro busy stays 1 and timeout stays 0.
- p0 request dropped in the cycle after ctl_cmd → p0_ack still pulses on completion; next arbitration sees no p0 request.
